nf10_output_demux: RTL and testbench
====================================

Name: nf10_output_demux

Overview:
- Inverse of the 5-to-1 input arbiter: takes one 256-bit AXI4-Stream packet stream and steers each packet to one or more of 5 output streams.
- The destination is a one-hot or multi-hot mask read from tuser on the first beat of each packet.
- Sits after the output port lookup, feeding the per-port output queues; supports multicast and drops packets with an empty mask.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width; tstrb width is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, tuser width.
- C_DST_PORT_POS, 24, LSB of the 5-bit destination mask in tuser; bit C_DST_PORT_POS+i selects port i.

Ports:
- axi_aclk  input  1  single clock; all logic is on the rising edge.
- axi_reset  input  1  asynchronous, active-high reset.
- s_axis_tdata  input  C_AXIS_DATA_WIDTH  input data.
- s_axis_tstrb  input  C_AXIS_DATA_WIDTH/8  input byte strobes.
- s_axis_tuser  input  C_AXIS_TUSER_WIDTH  input metadata; destination mask valid on the first beat only.
- s_axis_tvalid  input  1  input valid.
- s_axis_tready  output  1  input ready.
- s_axis_tlast  input  1  last beat of packet.
- m_axis_tdata_i, i=0..4  output  C_AXIS_DATA_WIDTH  per-port data; all ports driven from one shared beat register.
- m_axis_tstrb_i, i=0..4  output  C_AXIS_DATA_WIDTH/8  per-port strobes.
- m_axis_tuser_i, i=0..4  output  C_AXIS_TUSER_WIDTH  per-port tuser, forwarded unmodified.
- m_axis_tvalid_i, i=0..4  output  1  per-port valid.
- m_axis_tready_i, i=0..4  input  1  per-port ready.
- m_axis_tlast_i, i=0..4  output  1  per-port last.
- pkt_fwd_count  output  32  packets forwarded, counted once per packet, saturating.
- pkt_drop_count  output  32  packets dropped because the mask was empty, saturating.

Behaviour:
- Interface: one clock (axi_aclk); reset (axi_reset) is asynchronous and active-high.
- Reset values: all m_axis_tvalid_i=0, s_axis_tready=0 while axi_reset is asserted, beat register=0, pending mask=0, state=IDLE, both counters=0.
- Beat register: one shared register holding tdata/tstrb/tuser/tlast, plus a 5-bit pending mask.
- m_axis_tvalid_i = pending[i].
- pending[i] clears on the cycle m_axis_tvalid_i && m_axis_tready_i.
- s_axis_tready = ~axi_reset && ((pending & ~m_ready) == 0), i.e. every pending port is empty or completes this cycle. This gives full throughput for a single destination with ready held high.
- Input handshake: s_axis_tvalid && s_axis_tready. On an accepted non-dropped beat, the register loads and pending is set to the active mask on the next edge.
- Latency: exactly 1 cycle from input handshake to m_axis_tvalid_i.
- Multicast: a beat is retained until every masked port has accepted it. A port that accepts early deasserts its tvalid and never sees the beat twice.
- FSM states: IDLE, FWD, DROP.
  - IDLE: on a handshake, sample mask = s_axis_tuser[C_DST_PORT_POS+4:C_DST_PORT_POS].
    - mask!=0 and !tlast: latch mask, go to FWD, forward the beat.
    - mask!=0 and tlast: forward the single-beat packet, pkt_fwd_count+1, stay in IDLE.
    - mask==0: discard the beat, leave pending untouched, pkt_drop_count+1. Go to DROP if !tlast, else stay in IDLE.
  - FWD: forward each beat with the latched mask; tuser destination bits on middle beats are ignored. On the tlast beat: pkt_fwd_count+1, go to IDLE.
  - DROP: s_axis_tready follows the normal rule. Accepted beats are discarded; on the tlast beat, go to IDLE.
- Counters: each saturates at 32'hFFFFFFFF and does not wrap. Each increments at the input handshake of the counted beat.
- Backpressure: a stalled port holds the whole demux, including other destinations (head-of-line blocking is intended; queues sit downstream).
- Reset mid-packet: all state is cleared immediately and the partial packet is abandoned. After reset, the next input beat is treated as a first beat.
- Mask bits with index >=5 in tuser are ignored.

Test Plan:
- Unicast: 3-beat packet, mask=5'b00100, all readys=1 -> beats appear on port 2 only, one cycle after each handshake, back-to-back; tvalid_0/1/3/4 stay 0; pkt_fwd_count=1.
- Multicast with skew: 1-beat packet, mask=5'b10001, ready_0=1, ready_4 low for 3 cycles.
  - tvalid_0 pulses for 1 cycle only.
  - tvalid_4 is held 4 cycles.
  - s_axis_tready=0 until port 4 accepts.
- Drop: 4-beat packet with mask=0, followed by 1-beat packet mask=5'b00010 -> no output for the first packet; second appears on port 1; pkt_drop_count=1, pkt_fwd_count=1.
- Mid-packet mask change: 3-beat packet, first-beat mask=5'b00001, beat 2 tuser mask=5'b01000 -> all 3 beats on port 0 only.
- Reset mid-packet: assert axi_reset asynchronously during beat 2 of 4 (mask=5'b00001).
  - All tvalid_i drop to 0 immediately; counters are 0.
  - Next beat with mask=5'b00010 and tlast=1 goes to port 1.
- Counter saturation: force pkt_drop_count to 32'hFFFFFFFE, then drop 3 packets -> reads 32'hFFFFFFFF.

Source files
------------

// File: rtl/nf10_output_demux.sv
// nf10_output_demux
//   Steers each packet of one 256-bit AXI4-Stream input to any subset of
//   5 output streams. The subset is the destination mask taken from tuser on
//   the first beat of a packet. Packets whose mask is empty are discarded.
//   One shared beat register feeds every output port. A per-port pending bit
//   drives that port's tvalid. A beat is retained until every selected port
//   has taken it.
//
// Ports
//   axi_aclk, axi_reset          clock, async active-high reset
//   s_axis_*                     input stream (tdata/tstrb/tuser/tvalid/tlast, tready out)
//   m_axis_*_0 .. m_axis_*_4     output streams (tready in)
//   pkt_fwd_count                packets forwarded (once per packet, saturating)
//   pkt_drop_count               packets dropped for an empty mask (saturating)

// Per-port delivery flag. It is set when a beat is loaded for this port and
// cleared when the port handshakes.
module nf10_output_demux_port (
  input  logic axi_aclk,
  input  logic axi_reset,
  input  logic load,
  input  logic sel,
  input  logic ready,
  output logic pending
);
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset)    pending <= 1'b0;
    else if (load)    pending <= sel;
    else if (ready)   pending <= 1'b0;
  end
endmodule

module nf10_output_demux #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_DST_PORT_POS     = 24
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_0,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_0,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_0,
  output logic                            m_axis_tvalid_0,
  input  logic                            m_axis_tready_0,
  output logic                            m_axis_tlast_0,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_1,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_1,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_1,
  output logic                            m_axis_tvalid_1,
  input  logic                            m_axis_tready_1,
  output logic                            m_axis_tlast_1,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_2,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_2,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_2,
  output logic                            m_axis_tvalid_2,
  input  logic                            m_axis_tready_2,
  output logic                            m_axis_tlast_2,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_3,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_3,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_3,
  output logic                            m_axis_tvalid_3,
  input  logic                            m_axis_tready_3,
  output logic                            m_axis_tlast_3,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_4,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_4,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_4,
  output logic                            m_axis_tvalid_4,
  input  logic                            m_axis_tready_4,
  output logic                            m_axis_tlast_4,
  output logic [31:0]                     pkt_fwd_count,
  output logic [31:0]                     pkt_drop_count
);
  localparam int NUM_PORTS = 5;

  typedef struct packed {
    logic [C_AXIS_DATA_WIDTH-1:0]   tdata;
    logic [C_AXIS_DATA_WIDTH/8-1:0] tstrb;
    logic [C_AXIS_TUSER_WIDTH-1:0]  tuser;
    logic                           tlast;
  } beat_t;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t                 state, next_state;
  beat_t                  beat;
  logic [NUM_PORTS-1:0]   pending, m_ready, dst_mask, act_mask, mask_in;
  logic                   accept, load, fwd_inc, drop_inc;
  logic [31:0]            fwd_cnt, drop_cnt;

  assign m_ready = {m_axis_tready_4, m_axis_tready_3, m_axis_tready_2,
                    m_axis_tready_1, m_axis_tready_0};
  assign mask_in = s_axis_tuser[C_DST_PORT_POS +: NUM_PORTS];

  // Accept only when every outstanding port is done or finishing now.
  // A stalled port therefore blocks all destinations.
  assign s_axis_tready = ~axi_reset && ((pending & ~m_ready) == '0);
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) state <= IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    act_mask   = dst_mask;
    fwd_inc    = 1'b0;
    drop_inc   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (mask_in != '0) begin
          load     = 1'b1;
          act_mask = mask_in;
          if (s_axis_tlast) fwd_inc    = 1'b1;
          else              next_state = FWD;
        end else begin
          drop_inc = 1'b1;
          if (!s_axis_tlast) next_state = DROP;
        end
      end
      // Middle beats reuse the mask latched on the first beat.
      FWD: if (accept) begin
        load = 1'b1;
        if (s_axis_tlast) begin
          fwd_inc    = 1'b1;
          next_state = IDLE;
        end
      end
      DROP: if (accept && s_axis_tlast) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      beat     <= '0;
      dst_mask <= '0;
    end else if (load) begin
      beat     <= '{tdata: s_axis_tdata, tstrb: s_axis_tstrb,
                    tuser: s_axis_tuser, tlast: s_axis_tlast};
      dst_mask <= act_mask;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      fwd_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (fwd_inc  && fwd_cnt  != 32'hFFFF_FFFF) fwd_cnt  <= fwd_cnt + 32'd1;
      if (drop_inc && drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign pkt_fwd_count  = fwd_cnt;
  assign pkt_drop_count = drop_cnt;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    nf10_output_demux_port u_port (
      .axi_aclk  (axi_aclk),
      .axi_reset (axi_reset),
      .load      (load),
      .sel       (act_mask[i]),
      .ready     (m_ready[i]),
      .pending   (pending[i])
    );
  end

  assign {m_axis_tvalid_4, m_axis_tvalid_3, m_axis_tvalid_2,
          m_axis_tvalid_1, m_axis_tvalid_0} = pending;

  assign m_axis_tdata_0 = beat.tdata;  assign m_axis_tstrb_0 = beat.tstrb;
  assign m_axis_tuser_0 = beat.tuser;  assign m_axis_tlast_0 = beat.tlast;
  assign m_axis_tdata_1 = beat.tdata;  assign m_axis_tstrb_1 = beat.tstrb;
  assign m_axis_tuser_1 = beat.tuser;  assign m_axis_tlast_1 = beat.tlast;
  assign m_axis_tdata_2 = beat.tdata;  assign m_axis_tstrb_2 = beat.tstrb;
  assign m_axis_tuser_2 = beat.tuser;  assign m_axis_tlast_2 = beat.tlast;
  assign m_axis_tdata_3 = beat.tdata;  assign m_axis_tstrb_3 = beat.tstrb;
  assign m_axis_tuser_3 = beat.tuser;  assign m_axis_tlast_3 = beat.tlast;
  assign m_axis_tdata_4 = beat.tdata;  assign m_axis_tstrb_4 = beat.tstrb;
  assign m_axis_tuser_4 = beat.tuser;  assign m_axis_tlast_4 = beat.tlast;

endmodule

// File: tb/tb_nf10_output_demux.sv
module tb_nf10_output_demux;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [255:0] s_tdata;
  logic [31:0]  s_tstrb;
  logic [127:0] s_tuser;
  logic         s_tvalid, s_tlast, s_tready;
  logic [4:0]   m_rdy, m_vld, m_last;
  logic [255:0] m_data [5];
  logic [31:0]  m_strb [5];
  logic [127:0] m_user [5];
  logic [31:0]  fwd_cnt, drop_cnt;

  nf10_output_demux dut (
    .axi_aclk(clk), .axi_reset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata_0(m_data[0]), .m_axis_tstrb_0(m_strb[0]), .m_axis_tuser_0(m_user[0]),
    .m_axis_tvalid_0(m_vld[0]), .m_axis_tready_0(m_rdy[0]), .m_axis_tlast_0(m_last[0]),
    .m_axis_tdata_1(m_data[1]), .m_axis_tstrb_1(m_strb[1]), .m_axis_tuser_1(m_user[1]),
    .m_axis_tvalid_1(m_vld[1]), .m_axis_tready_1(m_rdy[1]), .m_axis_tlast_1(m_last[1]),
    .m_axis_tdata_2(m_data[2]), .m_axis_tstrb_2(m_strb[2]), .m_axis_tuser_2(m_user[2]),
    .m_axis_tvalid_2(m_vld[2]), .m_axis_tready_2(m_rdy[2]), .m_axis_tlast_2(m_last[2]),
    .m_axis_tdata_3(m_data[3]), .m_axis_tstrb_3(m_strb[3]), .m_axis_tuser_3(m_user[3]),
    .m_axis_tvalid_3(m_vld[3]), .m_axis_tready_3(m_rdy[3]), .m_axis_tlast_3(m_last[3]),
    .m_axis_tdata_4(m_data[4]), .m_axis_tstrb_4(m_strb[4]), .m_axis_tuser_4(m_user[4]),
    .m_axis_tvalid_4(m_vld[4]), .m_axis_tready_4(m_rdy[4]), .m_axis_tlast_4(m_last[4]),
    .pkt_fwd_count(fwd_cnt), .pkt_drop_count(drop_cnt)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat encoding: the tag is replicated through data/strb/user so that any
  // misrouted or stale beat is visible. tuser[31:29] are set to prove that
  // mask bits above port 4 are ignored.
  function automatic logic [255:0] mk_data(input logic [7:0] t); return {32{t}}; endfunction
  function automatic logic [31:0]  mk_strb(input logic [7:0] t); return {4{t}}; endfunction
  function automatic logic [127:0] mk_user(input logic [7:0] t, input logic [4:0] m);
    return {t, 88'h0, 3'b111, m, 16'h0, t};
  endfunction

  task automatic drive(input logic v, input logic l, input logic [4:0] m, input logic [7:0] t);
    s_tvalid = v; s_tlast = l;
    s_tdata = mk_data(t); s_tstrb = mk_strb(t); s_tuser = mk_user(t, m);
  endtask

  task automatic check_beat(input string name, input logic [4:0] ev, input logic [7:0] et,
                            input logic [4:0] em, input logic el);
    for (int p = 0; p < 5; p++) if (ev[p]) begin
      check({name, " tdata"}, m_data[p], mk_data(et));
      check({name, " tstrb"}, {224'h0, m_strb[p]}, {224'h0, mk_strb(et)});
      check({name, " tuser"}, {128'h0, m_user[p]}, {128'h0, mk_user(et, em)});
      check({name, " tlast"}, {255'h0, m_last[p]}, {255'h0, el});
    end
  endtask

  typedef struct {
    logic       vld; logic last; logic [4:0] mask; logic [7:0] tag; logic [4:0] rdy;
    logic       e_trdy; logic [4:0] e_vld; logic [7:0] e_tag; logic [4:0] e_umask;
    logic       e_last; int e_fwd; int e_drop;
  } vec_t;

  vec_t vecs [24];

  initial begin
    // Each row: inputs driven for one cycle, and what must be visible during that cycle.
    // unicast 3-beat to port 2
    vecs[0]  = '{1,0,5'h04,8'hA0,5'h1F, 1,5'h00,8'h00,5'h00,0, 0,0};
    vecs[1]  = '{1,0,5'h04,8'hA1,5'h1F, 1,5'h04,8'hA0,5'h04,0, 0,0};
    vecs[2]  = '{1,1,5'h04,8'hA2,5'h1F, 1,5'h04,8'hA1,5'h04,0, 0,0};
    vecs[3]  = '{0,0,5'h00,8'h00,5'h1F, 1,5'h04,8'hA2,5'h04,1, 1,0};
    vecs[4]  = '{0,0,5'h00,8'h00,5'h1F, 1,5'h00,8'h00,5'h00,0, 1,0};
    // 4-beat drop (middle masks must be ignored), then 1-beat to port 1
    vecs[5]  = '{1,0,5'h00,8'hB0,5'h1F, 1,5'h00,8'h00,5'h00,0, 1,0};
    vecs[6]  = '{1,0,5'h1F,8'hB1,5'h1F, 1,5'h00,8'h00,5'h00,0, 1,1};
    vecs[7]  = '{1,0,5'h02,8'hB2,5'h1F, 1,5'h00,8'h00,5'h00,0, 1,1};
    vecs[8]  = '{1,1,5'h00,8'hB3,5'h1F, 1,5'h00,8'h00,5'h00,0, 1,1};
    vecs[9]  = '{1,1,5'h02,8'hC0,5'h1F, 1,5'h00,8'h00,5'h00,0, 1,1};
    vecs[10] = '{0,0,5'h00,8'h00,5'h1F, 1,5'h02,8'hC0,5'h02,1, 2,1};
    vecs[11] = '{0,0,5'h00,8'h00,5'h1F, 1,5'h00,8'h00,5'h00,0, 2,1};
    // mid-packet mask change: stays on port 0, tuser forwarded unmodified
    vecs[12] = '{1,0,5'h01,8'hD0,5'h1F, 1,5'h00,8'h00,5'h00,0, 2,1};
    vecs[13] = '{1,0,5'h08,8'hD1,5'h1F, 1,5'h01,8'hD0,5'h01,0, 2,1};
    vecs[14] = '{1,1,5'h01,8'hD2,5'h1F, 1,5'h01,8'hD1,5'h08,0, 2,1};
    vecs[15] = '{0,0,5'h00,8'h00,5'h1F, 1,5'h01,8'hD2,5'h01,1, 3,1};
    vecs[16] = '{0,0,5'h00,8'h00,5'h1F, 1,5'h00,8'h00,5'h00,0, 3,1};
    // multicast to ports 0 and 4, port 4 stalled 3 cycles, next packet waiting
    vecs[17] = '{1,1,5'h11,8'hE0,5'h0F, 1,5'h00,8'h00,5'h00,0, 3,1};
    vecs[18] = '{1,1,5'h04,8'hF0,5'h0F, 0,5'h11,8'hE0,5'h11,1, 4,1};
    vecs[19] = '{1,1,5'h04,8'hF0,5'h0F, 0,5'h10,8'hE0,5'h11,1, 4,1};
    vecs[20] = '{1,1,5'h04,8'hF0,5'h0F, 0,5'h10,8'hE0,5'h11,1, 4,1};
    vecs[21] = '{1,1,5'h04,8'hF0,5'h1F, 1,5'h10,8'hE0,5'h11,1, 4,1};
    vecs[22] = '{0,0,5'h00,8'h00,5'h1F, 1,5'h04,8'hF0,5'h04,1, 5,1};
    vecs[23] = '{0,0,5'h00,8'h00,5'h1F, 1,5'h00,8'h00,5'h00,0, 5,1};

    drive(0, 0, 5'h00, 8'h00);
    m_rdy = 5'h1F;
    #2;
    check("reset tready",  {255'h0, s_tready}, 256'h0);
    check("reset tvalid",  {251'h0, m_vld}, 256'h0);
    check("reset fwd",     {224'h0, fwd_cnt}, 256'h0);
    check("reset drop",    {224'h0, drop_cnt}, 256'h0);
    check("reset beat",    m_data[0], 256'h0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].vld, vecs[i].last, vecs[i].mask, vecs[i].tag);
      m_rdy = vecs[i].rdy;
      #1;
      check($sformatf("row%0d tready", i), {255'h0, s_tready}, {255'h0, vecs[i].e_trdy});
      check($sformatf("row%0d tvalid", i), {251'h0, m_vld}, {251'h0, vecs[i].e_vld});
      check($sformatf("row%0d fwd", i), {224'h0, fwd_cnt}, 256'(vecs[i].e_fwd));
      check($sformatf("row%0d drop", i), {224'h0, drop_cnt}, 256'(vecs[i].e_drop));
      check_beat($sformatf("row%0d", i), vecs[i].e_vld, vecs[i].e_tag, vecs[i].e_umask, vecs[i].e_last);
      @(negedge clk);
    end

    // Reset in the middle of a 4-beat packet to port 0
    m_rdy = 5'h1F;
    drive(1, 0, 5'h01, 8'h60);
    @(negedge clk) drive(1, 0, 5'h01, 8'h61);
    #1 check("mid pkt tvalid", {251'h0, m_vld}, 256'h01);
    #2 rst = 1'b1;
    #1;
    check("async rst tvalid", {251'h0, m_vld}, 256'h0);
    check("async rst tready", {255'h0, s_tready}, 256'h0);
    check("async rst fwd",    {224'h0, fwd_cnt}, 256'h0);
    check("async rst drop",   {224'h0, drop_cnt}, 256'h0);
    @(negedge clk) rst = 1'b0;
    drive(1, 1, 5'h02, 8'h70);
    @(negedge clk) drive(0, 0, 5'h00, 8'h00);
    #1;
    check("post rst tvalid", {251'h0, m_vld}, 256'h02);
    check_beat("post rst", 5'h02, 8'h70, 5'h02, 1'b1);
    check("post rst fwd", {224'h0, fwd_cnt}, 256'd1);
    @(negedge clk);
    #1 check("post rst idle", {251'h0, m_vld}, 256'h0);

    // Drop counter saturation
    @(negedge clk) force dut.drop_cnt = 32'hFFFF_FFFE;
    #1 release dut.drop_cnt;
    drive(1, 1, 5'h00, 8'h80);
    @(negedge clk);
    #1 check("sat drop 1", {224'h0, drop_cnt}, {224'h0, 32'hFFFF_FFFF});
    @(negedge clk);
    @(negedge clk) drive(0, 0, 5'h00, 8'h00);
    #1;
    check("sat drop 3", {224'h0, drop_cnt}, {224'h0, 32'hFFFF_FFFF});
    check("sat no out", {251'h0, m_vld}, 256'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
